// File: rtl/nios2_mult_seq_cell_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nios2_mult_seq_cell_if                                                 |
// | Start/done handshake and operand/result bundle for the seq multiplier  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface nios2_mult_seq_cell_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic              cancel;
   logic [1:0]        op;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;

   modport master (
      output start, cancel, op, src1, src2,
      input  busy, done, result
   );

   modport slave (
      input  start, cancel, op, src1, src2,
      output busy, done, result
   );
endinterface
`default_nettype wire

// File: rtl/nios2_mult_seq_cell.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nios2_mult_seq_cell                                                    |
// | Multi-cycle MUL/MULXSS/MULXSU/MULXUU on one shared PART_W multiplier.  |
// | Optional: NIOS2_MULT_EARLY_OUT_EN skips all-zero upper |B| slices.     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module nios2_mult_seq_cell #(
   parameter int DATA_W = 32,
   parameter int PART_W = 16
) (
   input  wire logic               clk,
   input  wire logic               reset_n,
   nios2_mult_seq_cell_if.slave    bus
);
   localparam int N     = DATA_W / PART_W;
   localparam int ACC_W = 2 * DATA_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              neg_q, neg_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]  i_q, i_d;
   logic [IDX_W-1:0]  j_q, j_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] result_q, result_d;

   logic [PART_W-1:0]   a_sl, b_sl;
   logic [2*PART_W-1:0] pp;
   logic [ACC_W-1:0]    pp_sh;
   logic                i_last, j_last, mac_end;
   logic                ready, accept, neg_a, neg_b;

   // The single shared slice multiplier; operands are magnitudes, so unsigned.
   assign a_sl  = PART_W'(a_q >> (int'(i_q) * PART_W));
   assign b_sl  = PART_W'(b_q >> (int'(j_q) * PART_W));
   assign pp    = {{PART_W{1'b0}}, a_sl} * {{PART_W{1'b0}}, b_sl};
   assign pp_sh = ACC_W'(pp) << ((int'(i_q) + int'(j_q)) * PART_W);

   assign i_last = (i_q == IDX_W'(N - 1));
   assign j_last = (j_q == IDX_W'(N - 1));

`ifdef NIOS2_MULT_EARLY_OUT_EN
   logic b_rest_zero;
   assign b_rest_zero = ((b_q >> ((int'(j_q) + 1) * PART_W)) == '0);
   assign mac_end     = i_last & (j_last | b_rest_zero);
`else
   assign mac_end     = i_last & j_last;
`endif

   assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept = bus.start & ready & ~bus.cancel;
   assign neg_a  = bus.src1[DATA_W-1] & ((bus.op == 2'b01) | (bus.op == 2'b10));
   assign neg_b  = bus.src2[DATA_W-1] & (bus.op == 2'b01);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      i_d      = i_q;
      j_d      = j_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (accept) begin
               op_d    = bus.op;
               a_d     = neg_a ? -bus.src1 : bus.src1;
               b_d     = neg_b ? -bus.src2 : bus.src2;
               neg_d   = neg_a ^ neg_b;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               busy_d  = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            if (bus.cancel) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               acc_d = acc_q + pp_sh;
               i_d   = i_last ? '0 : i_q + IDX_W'(1);
               if (i_last) begin
                  j_d = j_last ? '0 : j_q + IDX_W'(1);
               end
               if (mac_end) begin
                  state_d = S_SIGN;
               end
            end
         end
         S_SIGN: begin
            busy_d = 1'b0;
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else begin
               acc_d    = neg_q ? -acc_q : acc_q;
               result_d = (op_q == 2'b00) ? acc_d[DATA_W-1:0] : acc_d[ACC_W-1:DATA_W];
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         i_q      <= i_d;
         j_q      <= j_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule
`default_nettype wire

// File: tb/tb_nios2_mult_seq_cell.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nios2_mult_seq_cell                                                 |
// | Directed + random bench against an arithmetic multiply reference.      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_nios2_mult_seq_cell;
   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   nios2_mult_seq_cell_if #(.DATA_W(32)) bus ();

   nios2_mult_seq_cell #(.DATA_W(32), .PART_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full-precision product, then pick the word the opcode asks for.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0]        p;
      case (op)
         2'b00:   p = {32'b0, a} * {32'b0, b};
         2'b01:   begin sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; p = sa * sb; end
         2'b10:   begin sa = {{32{a[31]}}, a}; sb = {32'b0, b};       p = sa * sb; end
         default: p = {32'b0, a} * {32'b0, b};
      endcase
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef NIOS2_MULT_EARLY_OUT_EN
      logic [31:0] mb;
      mb = (op == 2'b01 && b[31]) ? -b : b;
      return (mb[31:16] != 16'h0) ? 6 : 4;
`else
      return 6 + 0 * int'(op) + 0 * int'(b[0]);
`endif
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit poke);
      int edges;
      int busy_n;
      int lat;
      bit got;
      edges  = 0;
      busy_n = 0;
      got    = 1'b0;
      lat    = ref_lat(op, b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src1  = a;
      bus.src2  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.src1  = $urandom;
      bus.src2  = $urandom;
      edges     = 1;
      check("done_low_after_accept", 64'(bus.done), 64'd0);
      while (!got && edges < 64) begin
         if (bus.done) begin
            got = 1'b1;
         end else begin
            if (bus.busy) busy_n++;
            if (poke) bus.start = (edges == 2);
            @(posedge clk);
            #1;
            edges++;
         end
      end
      bus.start = 1'b0;
      check("done_seen", 64'(got), 64'd1);
      if (got) begin
         check("result", 64'(bus.result), 64'(exp));
         check("latency", 64'(edges), 64'(lat));
         check("busy_cycles", 64'(busy_n), 64'(lat - 1));
         check("busy_at_done", 64'(bus.busy), 64'd0);
      end
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 65535));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      n_checks   = 0;
      n_errors   = 0;
      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.op     = 2'b00;
      bus.src1   = '0;
      bus.src2   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b00, 32'h1234_5678, 32'h0000_0003, 32'h369D_0368, 1'b0);

      // Start pulsed while busy must neither change the result nor queue a second op.
      run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b1);
      watch_no_done("poke_not_queued", 8);

      // Cancel on the 2nd MAC cycle of a 3x3.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.src1 = 32'd3; bus.src2 = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      check("cancel_busy", 64'(bus.busy), 64'd0);
      watch_no_done("cancel_no_done", 10);
      check("cancel_result_kept", 64'(bus.result), 64'h2A);

      // Cancel together with start in IDLE: nothing accepted.
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.src1 = 32'd5; bus.src2 = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      check("cancel_start_busy", 64'(bus.busy), 64'd0);
      watch_no_done("cancel_start_no_done", 8);
      check("cancel_start_result", 64'(bus.result), 64'h2A);

      // Reset dropped mid-MAC clears outputs without waiting for a clock.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b11; bus.src1 = 32'hDEAD_BEEF; bus.src2 = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(bus.busy), 64'd0);
      check("rst_mid_done", 64'(bus.done), 64'd0);
      check("rst_mid_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      watch_no_done("rst_mid_no_done", 10);

      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom);
         ra  = pick_operand();
         rb  = pick_operand();
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         run_op(rop, ra, rb, ref_mul(rop, ra, rb), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
